// File: rtl/clint_pkg.sv
// Shared register offsets and the byte-lane merge helper for the CLINT timer block.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Wishbone-classic 32-bit slave bus bundle between the core load/store path and the CLINT.
// Handshake: a request is cyc & stb & !ack; the slave answers with ack for exactly one
// cycle on the edge after the request, with read data valid only while ack is high.
interface clint_timer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] wbs_addr_i;
    logic [31:0]       wbs_dat_i;
    logic [3:0]        wbs_sel_i;
    logic              wbs_we_i;
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic [31:0]       wbs_dat_o;
    logic              wbs_ack_o;

    modport master (
        output wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/clint_prescaler.sv
// mtime tick generator: counts 0..TICK_DIV-1 and pulses tick_o on the terminal count.
module clint_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam logic [15:0] TERM = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == TERM);
        cnt_d  = cnt_q + 16'd1;
        // A software write to mtime restarts the tick period from zero.
        if (clr_i || tick_o) cnt_d = 16'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/clint_timer.sv
// Machine-mode CLINT: 64-bit mtime/mtimecmp, msip, and the timer/software interrupt lines.
// Optional mtime prescaler is built only when CLINT_PRESCALER_EN is defined.
module clint_timer
    import clint_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int TICK_DIV = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    clint_timer_if.slave wbs,
    output logic         xint_mtip_o,
    output logic         xint_msip_o
);
    logic [ADDR_W-1:0] addr;
    logic              unused_addr_bits;
    logic [15:0]       off;
    logic              req, wr, tick;
    logic              wr_mtime_lo, wr_mtime_hi, wr_mtime;
    logic [31:0]       rd_data;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic        msip_out_q, msip_out_d;

    assign addr             = wbs.wbs_addr_i;
    assign unused_addr_bits = ^addr;

`ifdef CLINT_PRESCALER_EN
    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (wr_mtime),
        .tick_o (tick)
    );
`else
    localparam int tick_div_unused = TICK_DIV;
    assign tick = 1'b1;
`endif

    always_comb begin
        off         = {addr[15:2], 2'b00};
        req         = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
        wr          = req & wbs.wbs_we_i;
        wr_mtime_lo = wr && (off == CLINT_MTIME_LO) && (wbs.wbs_sel_i != 4'b0000);
        wr_mtime_hi = wr && (off == CLINT_MTIME_HI) && (wbs.wbs_sel_i != 4'b0000);
        wr_mtime    = wr_mtime_lo | wr_mtime_hi;

        unique case (off)
            CLINT_MSIP:        rd_data = {31'd0, msip_q};
            CLINT_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
            CLINT_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
            CLINT_MTIME_LO:    rd_data = mtime_q[31:0];
            CLINT_MTIME_HI:    rd_data = mtime_q[63:32];
            default:           rd_data = 32'd0;
        endcase

        ack_d = req;
        dat_d = (req && !wbs.wbs_we_i) ? rd_data : 32'd0;

        msip_d = msip_q;
        if (wr && (off == CLINT_MSIP) && wbs.wbs_sel_i[0]) msip_d = wbs.wbs_dat_i[0];

        mtimecmp_d = mtimecmp_q;
        if (wr && (off == CLINT_MTIMECMP_LO))
            mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
        if (wr && (off == CLINT_MTIMECMP_HI))
            mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i);

        // A bus write to either half suppresses the tick entirely for that cycle.
        mtime_d = mtime_q + {63'd0, tick};
        if (wr_mtime_lo)
            mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i)};
        if (wr_mtime_hi)
            mtime_d = {byte_merge(mtime_q[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i), mtime_q[31:0]};

        mtip_d     = (mtime_q >= mtimecmp_q);
        msip_out_d = msip_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            msip_out_q <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            msip_out_q <= msip_out_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign xint_mtip_o   = mtip_q;
    assign xint_msip_o   = msip_out_q;
endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed scenarios plus random bus traffic against
// a reference model that derives register values from edge counts and write history.
module tb_clint_timer;
  import clint_pkg::*;

`ifdef CLINT_PRESCALER_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic mtip, msip;

  clint_timer_if #(.ADDR_W(16)) bus ();

  clint_timer #(.ADDR_W(16), .TICK_DIV(D)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .wbs         (bus.slave),
    .xint_mtip_o (mtip),
    .xint_msip_o (msip)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // reference model: each register is a piecewise history anchored at the edge of its last write
  longint      edge_n = 0;
  longint      rst_edge;
  longint      base_edge, old_base_edge;
  logic [63:0] base_val, old_base_val;
  longint      cmp_edge;
  logic [63:0] cmp_cur, cmp_old;
  longint      msip_edge;
  logic        msip_cur, msip_old;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  function automatic logic [63:0] mtime_after(input longint x);
    if (x >= base_edge) return base_val + 64'((x - base_edge) / D);
    return old_base_val + 64'((x - old_base_edge) / D);
  endfunction

  function automatic logic [63:0] cmp_after(input longint x);
    return (x >= cmp_edge) ? cmp_cur : cmp_old;
  endfunction

  function automatic logic msip_after(input longint x);
    return (x >= msip_edge) ? msip_cur : msip_old;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] read_model(input logic [15:0] addr, input longint x);
    logic [63:0] v;
    case ({addr[15:2], 2'b00})
      CLINT_MSIP:        return {31'd0, msip_after(x)};
      CLINT_MTIMECMP_LO: begin v = cmp_after(x);   return v[31:0];  end
      CLINT_MTIMECMP_HI: begin v = cmp_after(x);   return v[63:32]; end
      CLINT_MTIME_LO:    begin v = mtime_after(x); return v[31:0];  end
      CLINT_MTIME_HI:    begin v = mtime_after(x); return v[63:32]; end
      default:           return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    rst_edge      = edge_n;
    base_edge     = edge_n;
    old_base_edge = edge_n;
    base_val      = 64'd0;
    old_base_val  = 64'd0;
    cmp_edge      = edge_n;
    cmp_cur       = '1;
    cmp_old       = '1;
    msip_edge     = edge_n;
    msip_cur      = 1'b0;
    msip_old      = 1'b0;
    exp_q.delete();
  endtask

  // model update for a write that committed on edge e
  task automatic model_write(input logic [15:0] addr, input logic [31:0] dat,
                             input logic [3:0] sel, input longint e);
    logic [63:0] prev;
    case ({addr[15:2], 2'b00})
      CLINT_MSIP: if (sel[0]) begin
        msip_old  = msip_after(e - 1);
        msip_cur  = dat[0];
        msip_edge = e;
      end
      CLINT_MTIMECMP_LO, CLINT_MTIMECMP_HI: begin
        prev = cmp_after(e - 1);
        cmp_old = prev;
        if (addr[2]) cmp_cur = {lane_merge(prev[63:32], dat, sel), prev[31:0]};
        else         cmp_cur = {prev[63:32], lane_merge(prev[31:0], dat, sel)};
        cmp_edge = e;
      end
      CLINT_MTIME_LO, CLINT_MTIME_HI: if (sel != 4'b0000) begin
        prev = mtime_after(e - 1);
        old_base_val  = base_val;
        old_base_edge = base_edge;
        if (addr[2]) base_val = {lane_merge(prev[63:32], dat, sel), prev[31:0]};
        else         base_val = {prev[63:32], lane_merge(prev[31:0], dat, sel)};
        base_edge = e;
      end
      default: ;
    endcase
  endtask

  // interrupt lines are registered from the state held after the previous edge
  task automatic check_irqs();
    logic exp_mtip, exp_msip;
    if (edge_n == rst_edge) begin
      exp_mtip = 1'b0;
      exp_msip = 1'b0;
    end else begin
      exp_mtip = (mtime_after(edge_n - 1) >= cmp_after(edge_n - 1));
      exp_msip = msip_after(edge_n - 1);
    end
    check_eq("mtip", {63'd0, mtip}, {63'd0, exp_mtip});
    check_eq("msip", {63'd0, msip}, {63'd0, exp_msip});
  endtask

  // advance one edge, then sample at the following falling edge
  task automatic step();
    @(posedge clk);
    edge_n++;
    if (!rst_n) model_reset();
    @(negedge clk);
    check_irqs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // driver: one full transfer starting and ending on a falling edge
  task automatic wb_xfer(input logic we, input logic [15:0] addr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic abort_rst,
                         output logic [31:0] rdat);
    check_eq("ack_idle", {63'd0, bus.wbs_ack_o}, 64'd0);
    bus.wbs_cyc_i  = 1'b1;
    bus.wbs_stb_i  = 1'b1;
    bus.wbs_we_i   = we;
    bus.wbs_addr_i = addr;
    bus.wbs_dat_i  = dat;
    bus.wbs_sel_i  = sel;
    rdat = 32'd0;
    if (abort_rst) begin
      rst_n = 1'b0;
      step();
      check_eq("abort_noack", {63'd0, bus.wbs_ack_o}, 64'd0);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      rst_n = 1'b1;
      step();
      check_eq("abort_noack2", {63'd0, bus.wbs_ack_o}, 64'd0);
      return;
    end
    if (!we) exp_q.push_back(read_model(addr, edge_n));
    step();
    check_eq("ack_rise", {63'd0, bus.wbs_ack_o}, 64'd1);
    rdat = bus.wbs_dat_o;
    if (!we) check_eq("rdata", {32'd0, rdat}, {32'd0, exp_q.pop_front()});
    else     model_write(addr, dat, sel, edge_n);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    step();
    check_eq("ack_pulse", {63'd0, bus.wbs_ack_o}, 64'd0);
  endtask

  task automatic wb_read(input logic [15:0] addr, output logic [31:0] rdat);
    wb_xfer(1'b0, addr, 32'd0, 4'hF, 1'b0, rdat);
  endtask

  task automatic wb_write(input logic [15:0] addr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, addr, dat, sel, 1'b0, unused_rd);
  endtask

  logic [15:0] offs [7];
  initial begin
    logic [31:0] rd;
    logic [63:0] mt;
    logic [31:0] t;
    logic        seen;
    offs[0] = CLINT_MSIP;     offs[1] = CLINT_MTIMECMP_LO; offs[2] = CLINT_MTIMECMP_HI;
    offs[3] = CLINT_MTIME_LO; offs[4] = CLINT_MTIME_HI;    offs[5] = 16'h1234;
    offs[6] = 16'h0008;

    bus.wbs_cyc_i  = 1'b0;
    bus.wbs_stb_i  = 1'b0;
    bus.wbs_we_i   = 1'b0;
    bus.wbs_addr_i = '0;
    bus.wbs_dat_i  = '0;
    bus.wbs_sel_i  = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    check_eq("rst_ack",  {63'd0, bus.wbs_ack_o}, 64'd0);
    check_eq("rst_dat",  {32'd0, bus.wbs_dat_o}, 64'd0);
    check_eq("rst_mtip", {63'd0, mtip}, 64'd0);
    check_eq("rst_msip", {63'd0, msip}, 64'd0);

    // idle count and reset values
    repeat (10) step();
    wb_read(CLINT_MTIME_LO, rd);
    check_eq("idle_mtime", {32'd0, rd}, {32'd0, 32'(10 / D)});
    wb_read(CLINT_MTIMECMP_LO, rd);
    check_eq("cmp_lo_rst", {32'd0, rd}, 64'hFFFF_FFFF);
    wb_read(CLINT_MTIMECMP_HI, rd);
    check_eq("cmp_hi_rst", {32'd0, rd}, 64'hFFFF_FFFF);
    wb_read(CLINT_MTIME_HI, rd);
    wb_read(CLINT_MSIP, rd);

    // carry from low to high half
    wb_write(CLINT_MTIME_HI, 32'd0, 4'hF);
    wb_write(CLINT_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    repeat (2 * D) begin
      wb_read(CLINT_MTIME_LO, rd);
      wb_read(CLINT_MTIME_HI, rd);
    end
    wb_read(CLINT_MTIME_HI, rd);
    check_eq("wrap_hi", {32'd0, rd}, 64'd1);

    // timer interrupt rise and clear
    wb_write(CLINT_MTIME_LO, 32'd100, 4'hF);
    wb_write(CLINT_MTIME_HI, 32'd0, 4'hF);
    mt = mtime_after(edge_n);
    t  = mt[31:0] + 32'(20 * D);
    wb_write(CLINT_MTIMECMP_LO, t, 4'hF);
    check_eq("mtip_before", {63'd0, mtip}, 64'd0);
    wb_write(CLINT_MTIMECMP_HI, 32'd0, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 100 * D && !seen; i++) begin
      step();
      seen = mtip;
    end
    check_eq("mtip_rise_seen", {63'd0, mtip}, 64'd1);
    wb_write(CLINT_MTIMECMP_HI, 32'd1, 4'hF);
    check_eq("mtip_clear", {63'd0, mtip}, 64'd0);

    // software interrupt bit and byte lanes
    wb_write(CLINT_MSIP, 32'd1, 4'b0001);
    check_eq("msip_set", {63'd0, msip}, 64'd1);
    wb_write(CLINT_MSIP, 32'd0, 4'b0010);
    check_eq("msip_hold", {63'd0, msip}, 64'd1);
    wb_read(CLINT_MSIP, rd);
    check_eq("msip_rd", {32'd0, rd}, 64'd1);
    wb_write(CLINT_MSIP, 32'd0, 4'b0001);
    check_eq("msip_clr", {63'd0, msip}, 64'd0);

    // unmapped offset
    wb_read(16'h1234, rd);
    check_eq("unmapped_rd", {32'd0, rd}, 64'd0);
    wb_write(16'h1234, 32'hFFFF_FFFF, 4'hF);
    wb_read(CLINT_MTIMECMP_HI, rd);
    check_eq("unmapped_nochg", {32'd0, rd}, 64'd1);
    wb_read(CLINT_MSIP, rd);

    // reset landing on a pending write drops it
    wb_xfer(1'b1, CLINT_MTIME_HI, 32'h0000_DEAD, 4'hF, 1'b1, rd);
    repeat (5) step();
    wb_read(CLINT_MTIME_HI, rd);
    check_eq("abort_hi", {32'd0, rd}, 64'd0);
    wb_read(CLINT_MTIMECMP_LO, rd);
    check_eq("abort_cmp", {32'd0, rd}, 64'hFFFF_FFFF);

    // random traffic
    for (int n = 0; n < 120; n++) begin
      logic [15:0] a;
      logic [31:0] d;
      int k;
      k = $urandom_range(0, 6);
      a = offs[k] | 16'($urandom_range(0, 3));
      d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      if ($urandom_range(0, 1)) wb_write(a, d, 4'($urandom_range(0, 15)));
      else                      wb_read(a, rd);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
